// File: rtl/pulse_delay_sched.sv
// pulse_delay_sched
//   Reissues each accepted single-cycle trigger as a single-cycle output
//   pulse De+1 cycles later. De is delay_cfg, with 0 treated as 1. Up to
//   DEPTH triggers may be in flight. Each one is stored as an absolute due
//   timestamp in a small circular FIFO. Only the FIFO head is compared
//   against the free-running timestamp.
//
// Ports
//   clk        system clock; all state updates on the rising edge
//   reset      asynchronous, active-high; clears all state
//   trig       trigger request, sampled on each rising edge
//   delay_cfg  requested delay in cycles (0 behaves as 1)
//   ovf_clr    clears the sticky overflow flag (a new drop wins)
//   pulse_out  registered single-cycle delayed pulse
//   busy       high while any trigger is pending (registered)
//   pending    number of queued triggers (registered)
//   overflow   sticky flag: a trigger arrived on a full queue and was dropped

module pulse_delay_sched #(
    parameter int CNT_W = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     trig,
    input  logic [CNT_W-1:0]         delay_cfg,
    input  logic                     ovf_clr,
    output logic                     pulse_out,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [CNT_W-1:0] ts;
    logic [CNT_W-1:0] dly_q;
    logic [CNT_W-1:0] due_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    logic [CNT_W-1:0] de;
    logic [CNT_W-1:0] dly_use;
    logic             pop;
    logic             full;
    logic             accept;
    logic             drop;
    logic [PTR_W:0]   pending_nxt;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        de          = (delay_cfg == '0) ? CNT_W'(1) : delay_cfg;
        // The delay is locked while the queue holds anything. A constant
        // delay keeps the entries in due-time order, so comparing only the
        // head is sufficient.
        dly_use     = (pending == '0) ? de : dly_q;
        pop         = (pending != '0) && (due_mem[rd_ptr] == ts);
        full        = (pending == (PTR_W+1)'(DEPTH));
        // A pop in this cycle frees a slot, so a trigger on a full queue is
        // accepted whenever the head is leaving.
        accept      = trig && (!full || pop);
        drop        = trig && full && !pop;
        pending_nxt = pending;
        if (accept && !pop) begin
            pending_nxt = pending + (PTR_W+1)'(1);
        end else if (!accept && pop) begin
            pending_nxt = pending - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments, so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            ts        <= '0;
            dly_q     <= CNT_W'(1);
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            pending   <= '0;
            busy      <= 1'b0;
            pulse_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            ts        <= ts + CNT_W'(1);
            pending   <= pending_nxt;
            busy      <= (pending_nxt != '0);
            pulse_out <= pop;
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (pending == '0) begin
                    dly_q <= de;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // NOTE: the due-time storage has no reset. After reset the pointers and
    // pending are zero, so stale entries are never read.
    always_ff @(posedge clk) begin
        if (accept) begin
            due_mem[wr_ptr] <= ts + dly_use;
        end
    end

endmodule

// File: tb/tb_pulse_delay_sched.sv
module tb_pulse_delay_sched;

    logic       clk;
    logic       reset;
    logic       trig;
    logic [7:0] delay_cfg;
    logic       ovf_clr;
    logic       pulse_out;
    logic       busy;
    logic [2:0] pending;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    pulse_delay_sched #(.CNT_W(8), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .trig      (trig),
        .delay_cfg (delay_cfg),
        .ovf_clr   (ovf_clr),
        .pulse_out (pulse_out),
        .busy      (busy),
        .pending   (pending),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model. The queue holds the absolute cycle numbers in which
    // future pulses must appear. cyc is the index of the current cycle,
    // counted from the release of reset.
    int cyc    = 0;
    int mq[$];
    int m_lock = 1;
    bit m_pulse = 0;
    bit m_ovf   = 0;
    int m_sz;
    bit m_pop;
    int m_de;

    // Per-cycle history and pulse log for the directed literal checks.
    int   pulse_log[$];
    logic busy_hist [1024];
    logic ovf_hist  [1024];
    int   pend_hist [1024];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    // Model update on each rising edge. A trigger in cycle c pulses in cycle
    // c+De+1.
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                mq.delete();
                m_lock  = 1;
                m_pulse = 0;
                m_ovf   = 0;
                cyc     = 0;
            end else begin
                m_sz  = mq.size();
                m_pop = (m_sz > 0) && (mq[0] == cyc + 1);
                if (m_pop) void'(mq.pop_front());
                if (trig) begin
                    if (m_sz < 4 || m_pop) begin
                        m_de = (delay_cfg == 0) ? 1 : int'(delay_cfg);
                        if (m_sz == 0) m_lock = m_de;
                        mq.push_back(cyc + m_lock + 1);
                        if (ovf_clr) m_ovf = 0;
                    end else begin
                        m_ovf = 1;
                    end
                end else if (ovf_clr) begin
                    m_ovf = 0;
                end
                m_pulse = m_pop;
                cyc     = cyc + 1;
            end
        end
    end

    // Compare process: compares the DUT outputs with the model on every
    // falling edge outside reset.
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b0) begin
                check("pulse_out", pulse_out, m_pulse);
                check("pending", pending, mq.size());
                check("busy", busy, mq.size() != 0);
                check("overflow", overflow, m_ovf);
                if (pulse_out === 1'b1) pulse_log.push_back(cyc);
                if (cyc < 1024) begin
                    busy_hist[cyc] = busy;
                    ovf_hist[cyc]  = overflow;
                    pend_hist[cyc] = int'(pending);
                end
            end
        end
    end

    // Asserts reset asynchronously between edges and confirms that all
    // outputs clear immediately. It returns on a falling edge with reset
    // released, in cycle 0.
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset   = 1'b1;
        trig    = 1'b0;
        ovf_clr = 1'b0;
        #1;
        check("reset pulse_out", pulse_out, 0);
        check("reset busy", busy, 0);
        check("reset pending", pending, 0);
        check("reset overflow", overflow, 0);
        @(negedge clk);
        pulse_log.delete();
        for (int i = 0; i < 1024; i++) begin
            busy_hist[i] = 1'bx;
            ovf_hist[i]  = 1'bx;
            pend_hist[i] = -1;
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Advances to the falling edge inside cycle n. Single-cycle inputs are
    // cleared on the way, so a caller can then set trig for cycle n.
    task automatic wait_cycle(input int n);
        while (cyc < n) begin
            @(negedge clk);
            trig    = 1'b0;
            ovf_clr = 1'b0;
        end
    endtask

    initial begin
        reset     = 1'b1;
        trig      = 1'b0;
        delay_cfg = 8'd0;
        ovf_clr   = 1'b0;

        // Single trigger.
        do_reset();
        delay_cfg = 8'd5;
        wait_cycle(10); trig = 1'b1;
        wait_cycle(20);
        check("single count", pulse_log.size(), 1);
        check("single cycle", pulse_log[0], 16);
        check("single busy c10", busy_hist[10], 0);
        for (int c = 11; c <= 15; c++) check("single busy window", busy_hist[c], 1);
        check("single busy c16", busy_hist[16], 0);
        check("single pending c15", pend_hist[15], 1);
        check("single pending c16", pend_hist[16], 0);

        // Zero delay behaves as a delay of one.
        do_reset();
        delay_cfg = 8'd0;
        wait_cycle(3); trig = 1'b1;
        wait_cycle(10);
        check("zero count", pulse_log.size(), 1);
        check("zero cycle", pulse_log[0], 5);

        // Burst: the fifth trigger is dropped; then the sticky flag is cleared.
        do_reset();
        delay_cfg = 8'd10;
        for (int t = 0; t <= 4; t++) begin
            wait_cycle(t); trig = 1'b1;
        end
        wait_cycle(20); ovf_clr = 1'b1;
        wait_cycle(25);
        check("burst count", pulse_log.size(), 4);
        for (int k = 0; k < 4; k++) check("burst cycle", pulse_log[k], 11 + k);
        check("burst ovf c4", ovf_hist[4], 0);
        check("burst ovf c5", ovf_hist[5], 1);
        check("burst ovf c20", ovf_hist[20], 1);
        check("burst ovf c21", ovf_hist[21], 0);

        // Delay is locked until the queue drains.
        do_reset();
        delay_cfg = 8'd8;
        wait_cycle(0); trig = 1'b1;
        wait_cycle(2); delay_cfg = 8'd3; trig = 1'b1;
        wait_cycle(20); trig = 1'b1;
        wait_cycle(30);
        check("lock count", pulse_log.size(), 3);
        check("lock p0", pulse_log[0], 9);
        check("lock p1", pulse_log[1], 11);
        check("lock p2", pulse_log[2], 24);

        // Wrap: the due time falls below ts and is reached after ts wraps.
        do_reset();
        delay_cfg = 8'd255;
        wait_cycle(200); trig = 1'b1;
        wait_cycle(470);
        check("wrap count", pulse_log.size(), 1);
        check("wrap cycle", pulse_log[0], 456);

        // A trigger on a full queue in a pop cycle is accepted.
        do_reset();
        delay_cfg = 8'd4;
        for (int t = 0; t <= 4; t++) begin
            wait_cycle(t); trig = 1'b1;
        end
        wait_cycle(15);
        check("fullpop count", pulse_log.size(), 5);
        for (int k = 0; k < 5; k++) check("fullpop cycle", pulse_log[k], 5 + k);
        check("fullpop pending c4", pend_hist[4], 4);
        check("fullpop pending c5", pend_hist[5], 4);
        check("fullpop ovf c5", ovf_hist[5], 0);
        check("fullpop ovf c6", ovf_hist[6], 0);

        // Reset with three triggers in flight; then a fresh single trigger.
        do_reset();
        delay_cfg = 8'd20;
        for (int t = 0; t <= 2; t++) begin
            wait_cycle(t); trig = 1'b1;
        end
        wait_cycle(5);
        check("midflight pending", pending, 3);
        do_reset();
        delay_cfg = 8'd5;
        wait_cycle(10); trig = 1'b1;
        wait_cycle(45);
        check("post-reset count", pulse_log.size(), 1);
        check("post-reset cycle", pulse_log[0], 16);

        // Randomized traffic against the model.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int i = 0; i < 1500; i++) begin
                @(negedge clk);
                case (r % 3)
                    0: begin
                        trig      = ($urandom_range(0, 99) < 60);
                        delay_cfg = 8'($urandom_range(0, 6));
                    end
                    1: begin
                        trig      = ($urandom_range(0, 99) < 30);
                        delay_cfg = 8'($urandom_range(0, 15));
                    end
                    default: begin
                        trig      = ($urandom_range(0, 99) < 10);
                        delay_cfg = 8'($urandom_range(240, 255));
                    end
                endcase
                ovf_clr = ($urandom_range(0, 15) == 0);
            end
        end
        @(negedge clk);
        trig    = 1'b0;
        ovf_clr = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
